lsu_mem_ctrl: RTL and testbench

Sequences load/store operations from the core onto a single-port, word-addressed data memory with a req/ack handshake. Handles byte/halfword extraction with sign or zero extension, and read-modify-write for sub-word stores. Detects misaligned accesses and memory timeouts. Sits between the execute stage and the data memory, replacing the purely combinational load/store path.

---
 rtl/lsu_mem_ctrl_pkg.sv | 41 ++++
 rtl/lsu_mem_ctrl_if.sv | 34 +++
 rtl/lsu_lane_align.sv | 54 +++++
 rtl/lsu_mem_ctrl.sv | 159 +++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types for the load/store memory controller: opcodes, FSM states
// and the alignment helpers used when a request is accepted.
package lsu_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        LSU_LB  = 3'd0,
        LSU_LH  = 3'd1,
        LSU_LW  = 3'd2,
        LSU_LBU = 3'd3,
        LSU_LHU = 3'd4,
        LSU_SB  = 3'd5,
        LSU_SH  = 3'd6,
        LSU_SW  = 3'd7
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    localparam int TMO_W = 8;

    function automatic logic is_misaligned(lsu_op_t op, logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (op)
            LSU_LH, LSU_LHU, LSU_SH: mis = off[0];
            LSU_LW, LSU_SW:          mis = (off != 2'b00);
            default:                 mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic is_load(lsu_op_t op);
        return (op == LSU_LB) || (op == LSU_LH) || (op == LSU_LW) ||
               (op == LSU_LBU) || (op == LSU_LHU);
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core request/response and data-memory bus of the load/store controller.
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
// mem_req is held until the edge that samples mem_ack; rsp_valid is a single-cycle pulse.
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, mem_rdata, mem_ack,
        output req_ready, rsp_valid, rsp_data, rsp_err,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, mem_rdata, mem_ack,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: extracts/extends load data from a memory word
// and merges sub-word store data into the word read back from memory.
module lsu_lane_align
    import lsu_mem_ctrl_pkg::*;
(
    input  lsu_op_t     op,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];

        load_data = rdata;
        case (op)
            LSU_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            LSU_LBU: load_data = {24'h0, byte_sel};
            LSU_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            LSU_LHU: load_data = {16'h0, half_sel};
            default: load_data = rdata;
        endcase

        store_word = wdata;
        case (op)
            LSU_SB: begin
                store_word = rdata;
                case (off)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            LSU_SH: begin
                store_word = rdata;
                if (off[1]) store_word[31:16] = wdata[15:0];
                else        store_word[15:0]  = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: sequences core requests onto a single-port word memory,
// doing read-modify-write for SB/SH and flagging misalignment and memory timeouts.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_mem_ctrl_if.master bus,
    output lsu_state_t    dbg_state
);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    lsu_state_t        state_q, state_d;
    lsu_op_t           op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_err_q, res_err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] ld_data, st_word;
    lsu_op_t           in_op;

    assign in_op = lsu_op_t'(bus.req_op);

    lsu_lane_align u_align (
        .op        (op_q),
        .off       (off_q),
        .rdata     (bus.mem_rdata),
        .wdata     (wdata_q),
        .load_data (ld_data),
        .store_word(st_word)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_d       = in_op;
                    off_d      = bus.req_addr[1:0];
                    wdata_d    = bus.req_wdata;
                    mem_addr_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
                    res_data_d = '0;
                    res_err_d  = 1'b0;
                    cnt_d      = '0;
                    if (is_misaligned(in_op, bus.req_addr[1:0])) begin
                        res_err_d = 1'b1;
                        state_d   = RESP;
                    end else if (in_op == LSU_SW) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = bus.req_wdata;
                        state_d     = WR;
                    end else begin
                        mem_we_d = 1'b0;
                        state_d  = RD;
                    end
                end
            end
            RD: begin
                if (bus.mem_ack) begin
                    if (is_load(op_q)) begin
                        res_data_d = ld_data;
                        state_d    = RESP;
                    end else begin
                        mem_wdata_d = st_word;
                        mem_we_d    = 1'b1;
                        cnt_d       = '0;
                        state_d     = WR;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    res_err_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR: begin
                // Ack is checked before the counter so a last-cycle ack still completes.
                if (bus.mem_ack) begin
                    state_d = RESP;
                end else if (cnt_q == TMO_LAST) begin
                    res_err_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                mem_we_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
        mem_req_d = (state_d == RD) || (state_d == WR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= LSU_LB;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= (state_q == RESP);
            rsp_data_q  <= (state_q == RESP) ? res_data_q : '0;
            rsp_err_q   <= (state_q == RESP) && res_err_q;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: behavioural word memory responder, scoreboard queues
// for responses, reads and writes, directed cases then a short random run.
module tb_lsu_mem_ctrl;
  import lsu_mem_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  lsu_state_t dbg_state;

  lsu_mem_ctrl_if bus();

  lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.master),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          exp_lat_q[$];
  int          start_q[$];
  logic [31:0] exp_rd_q[$];
  logic [63:0] exp_wr_q[$];

  logic [31:0] mem [0:1023];
  logic        rd_ack_en = 1'b1;
  logic        wr_ack_en = 1'b1;
  int          mem_req_cyc = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // reference model
  function automatic logic is_mis(logic [2:0] op, logic [1:0] off);
    if (op == 3'd1 || op == 3'd4 || op == 3'd6) return off[0];
    if (op == 3'd2 || op == 3'd7) return off != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] op, logic [31:0] w, logic [1:0] off);
    logic [31:0] sh;
    sh = w >> (8 * off);
    case (op)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd2:    return w;
      3'd3:    return {24'h0, sh[7:0]};
      3'd4:    return {16'h0, sh[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(logic [2:0] op, logic [31:0] w, logic [31:0] wd, logic [1:0] off);
    logic [31:0] m;
    if (op == 3'd5)      m = 32'h0000_00FF << (8 * off);
    else if (op == 3'd6) m = 32'h0000_FFFF << (8 * off);
    else return wd;
    return (w & ~m) | ((wd << (8 * off)) & m);
  endfunction

  // memory responder: ack is raised at the negedge so the next posedge samples it
  initial forever begin
    logic [63:0] ew;
    logic [31:0] ea;
    @(negedge clk);
    if (bus.mem_req) mem_req_cyc++;
    bus.mem_ack   = bus.mem_req && (bus.mem_we ? wr_ack_en : rd_ack_en);
    bus.mem_rdata = mem[bus.mem_addr[11:2]];
    if (bus.mem_ack && bus.mem_we) begin
      if (exp_wr_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
      else begin
        ew = exp_wr_q.pop_front();
        check("wr_addr", bus.mem_addr, ew[63:32]);
        check("wr_data", bus.mem_wdata, ew[31:0]);
      end
      mem[bus.mem_addr[11:2]] = bus.mem_wdata;
    end else if (bus.mem_ack) begin
      if (exp_rd_q.size() == 0) check("unexpected_read", 32'd1, 32'd0);
      else begin
        ea = exp_rd_q.pop_front();
        check("rd_addr", bus.mem_addr, ea);
      end
    end
  end

  // response monitor
  initial forever begin
    logic [31:0] ed;
    logic        ee;
    int          el, st;
    @(negedge clk);
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
      else begin
        ed = exp_q.pop_front();
        ee = exp_err_q.pop_front();
        el = exp_lat_q.pop_front();
        st = start_q.pop_front();
        check("rsp_data", bus.rsp_data, ed);
        check("rsp_err", 32'(bus.rsp_err), 32'(ee));
        check("rsp_latency", 32'(cyc - st), 32'(el));
      end
    end
  end

  task automatic wait_rsp();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("rsp_wait_expired", 32'(exp_q.size()), 32'd0);
      exp_q.delete(); exp_err_q.delete(); exp_lat_q.delete(); start_q.delete();
    end
  endtask

  // driver
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) check("req_ready_wait", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    exp_q.push_back(exp_data);
    exp_err_q.push_back(exp_err);
    exp_lat_q.push_back(exp_lat);
    start_q.push_back(cyc);
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_rsp();
  endtask

  initial begin
    int mrc, n;
    logic [2:0]  op;
    logic [31:0] addr, wd, w, nw;

    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[32'h100 >> 2] = 32'h80FF_1234;
    mem[32'h200 >> 2] = 32'h9ABC_5678;
    mem[32'h300 >> 2] = 32'h1122_3344;
    mem[32'h500 >> 2] = 32'h0102_0304;
    for (int i = 0; i < 4; i++) mem[(32'h600 >> 2) + i] = $urandom;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;

    // directed loads
    exp_rd_q.push_back(32'h100);
    do_req(3'd0, 32'h103, 32'h0, 32'hFFFF_FF80, 1'b0, 3);
    exp_rd_q.push_back(32'h200);
    do_req(3'd4, 32'h202, 32'h0, 32'h0000_9ABC, 1'b0, 3);
    exp_rd_q.push_back(32'h200);
    do_req(3'd1, 32'h202, 32'h0, 32'hFFFF_9ABC, 1'b0, 3);
    exp_rd_q.push_back(32'h200);
    do_req(3'd2, 32'h200, 32'h0, 32'h9ABC_5678, 1'b0, 3);
    exp_rd_q.push_back(32'h200);
    do_req(3'd3, 32'h201, 32'h0, 32'h0000_0056, 1'b0, 3);

    // sub-word stores (read-modify-write) and full word store
    exp_rd_q.push_back(32'h300);
    exp_wr_q.push_back({32'h300, 32'h1122_AA44});
    do_req(3'd5, 32'h301, 32'h0000_00AA, 32'h0, 1'b0, 4);
    exp_rd_q.push_back(32'h300);
    exp_wr_q.push_back({32'h300, 32'hBEEF_AA44});
    do_req(3'd6, 32'h302, 32'h1234_BEEF, 32'h0, 1'b0, 4);
    exp_wr_q.push_back({32'h400, 32'hCAFE_F00D});
    do_req(3'd7, 32'h400, 32'hCAFE_F00D, 32'h0, 1'b0, 3);
    exp_rd_q.push_back(32'h400);
    do_req(3'd2, 32'h400, 32'h0, 32'hCAFE_F00D, 1'b0, 3);

    // misaligned: error after two cycles, memory untouched
    mrc = mem_req_cyc;
    do_req(3'd7, 32'h402, 32'h5555_5555, 32'h0, 1'b1, 2);
    do_req(3'd1, 32'h201, 32'h0, 32'h0, 1'b1, 2);
    do_req(3'd2, 32'h101, 32'h0, 32'h0, 1'b1, 2);
    do_req(3'd6, 32'h303, 32'h0, 32'h0, 1'b1, 2);
    check("misaligned_mem_req_cycles", 32'(mem_req_cyc - mrc), 32'd0);

    // timeout: 255 wait cycles in RD, then RESP, then rsp_valid
    rd_ack_en = 1'b0;
    do_req(3'd2, 32'h100, 32'h0, 32'h0, 1'b1, 257);
    check("tmo_mem_req", 32'(bus.mem_req), 32'd0);
    check("tmo_req_ready", 32'(bus.req_ready), 32'd1);
    rd_ack_en = 1'b1;

    // reset during the write phase of SH
    wr_ack_en = 1'b0;
    exp_rd_q.push_back(32'h500);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd6;
    bus.req_addr  = 32'h502;
    bus.req_wdata = 32'h0000_5555;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!(bus.mem_req && bus.mem_we) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("sh_in_write", 32'(bus.mem_req && bus.mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr_ack_en = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_mem_word", mem[32'h500 >> 2], 32'h0102_0304);
    exp_rd_q.push_back(32'h500);
    do_req(3'd2, 32'h500, 32'h0, 32'h0102_0304, 1'b0, 3);

    // random mix against the reference model
    for (int i = 0; i < 14; i++) begin
      op   = 3'($urandom_range(0, 7));
      addr = 32'h600 + 32'($urandom_range(0, 15));
      wd   = $urandom;
      w    = mem[addr[11:2]];
      if (is_mis(op, addr[1:0])) begin
        do_req(op, addr, wd, 32'h0, 1'b1, 2);
      end else if (op <= 3'd4) begin
        exp_rd_q.push_back({addr[31:2], 2'b00});
        do_req(op, addr, wd, ref_load(op, w, addr[1:0]), 1'b0, 3);
      end else if (op == 3'd7) begin
        exp_wr_q.push_back({{addr[31:2], 2'b00}, wd});
        do_req(op, addr, wd, 32'h0, 1'b0, 3);
      end else begin
        nw = ref_store(op, w, wd, addr[1:0]);
        exp_rd_q.push_back({addr[31:2], 2'b00});
        exp_wr_q.push_back({{addr[31:2], 2'b00}, nw});
        do_req(op, addr, wd, 32'h0, 1'b0, 4);
      end
    end

    repeat (4) @(negedge clk);
    check("reads_left", 32'(exp_rd_q.size()), 32'd0);
    check("writes_left", 32'(exp_wr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
